// File: rtl/pc_fetch_unit.sv
// PC stage: holds the fetch PC and selects the next one (jr > jump > branch > pc+4); halt/fault FSM.
// Latency: a redirect shows on pc the cycle after the edge, no bubbles. Backpressure: stall holds pc, state and count.
// Optional PC_BOUNDS_CHECK_EN: an out-of-range next PC is not loaded and the unit parks in FAULT.
module pc_fetch_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC  = '0,
    parameter int              IMEM_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_off,
    input  logic            jump,
    input  logic [25:0]     jump_idx,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

`ifdef PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [PC_W-1:0] DEPTH_W = PC_W'(IMEM_DEPTH);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [PC_W-1:0] next_pc, br_pc, jmp_pc, jr_pc;
    logic            out_of_range;

    always_comb begin
        pc_plus4 = pc_q + PC_W'(4);
        jr_pc    = jr_target & ~PC_W'(3);
        jmp_pc   = {pc_plus4[PC_W-1:28], jump_idx, 2'b00};
        br_pc    = pc_plus4 + {{(PC_W-18){branch_off[15]}}, branch_off, 2'b00};

        if (jr)                next_pc = jr_pc;
        else if (jump)         next_pc = jmp_pc;
        else if (branch_taken) next_pc = br_pc;
        else                   next_pc = pc_plus4;

        out_of_range = BOUNDS_EN && ((next_pc >> 2) >= DEPTH_W);

        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        // halt_req still lets the redirect land; the unit stops after it
        if (state_q == S_RUN && !stall) begin
            if (out_of_range) begin
                state_d = S_FAULT;
            end else begin
                pc_d  = next_pc;
                cnt_d = cnt_q + 32'd1;
                if (halt_req) state_d = S_HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_count = cnt_q;
    assign fetch_valid = (state_q == S_RUN) && !stall;
    assign halted      = (state_q == S_HALT);
`ifdef PC_BOUNDS_CHECK_EN
    assign fault       = (state_q == S_FAULT);
`else
    assign fault       = 1'b0;
`endif

endmodule
